// File: rtl/otter_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : otter_hazard_unit
// Description : Hazard and forwarding controller for the pipelined OTTER CPU.
//               Tracks every in-flight instruction from EX to WB and derives
//               EX operand forwarding selects, load-use stalls, EX bubbles
//               and control-flow flushes from that scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_hazard_unit #(
    parameter int NUM_STAGES   = 3,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16,
    localparam int SW          = $clog2(NUM_STAGES + 1)
) (
    input  logic             CLK,
    input  logic             RESET_N,

    input  logic             de_valid,
    input  logic [4:0]       de_rs1_addr,
    input  logic [4:0]       de_rs2_addr,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [4:0]       de_rd_addr,
    input  logic             de_reg_write,
    input  logic             de_is_load,
    input  logic             ex_redirect,

    output logic             stall,
    output logic             ex_bubble,
    output logic             flush,
    output logic [SW-1:0]    fwd_sel_a,
    output logic [SW-1:0]    fwd_sel_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Scoreboard storage. Stage 1 = EX, stage NUM_STAGES = WB.
    // Source-register fields only matter while an entry sits in EX, so
    // they are kept for stage 1 alone. The load flag only matters while a
    // load's data is still unavailable, so it is kept for stages
    // 1..LOAD_LATENCY only.
    // ------------------------------------------------------------------
    logic [NUM_STAGES:1]   r_valid;
    logic [NUM_STAGES:1]   r_reg_write;
    logic [4:0]            r_rd [1:NUM_STAGES];
    logic [LOAD_LATENCY:1] r_is_load;

    logic [4:0]            r_ex_rs1;
    logic [4:0]            r_ex_rs2;
    logic                  r_ex_rs1_used;
    logic                  r_ex_rs2_used;

    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;

    // Combinational hazard terms
    logic                  w_accept;
    logic                  w_load_hazard;
    logic                  w_stall;
    logic [NUM_STAGES:2]   w_prod_a;
    logic [NUM_STAGES:2]   w_prod_b;
    logic [LOAD_LATENCY:1] w_load_hit;
    logic [SW-1:0]         w_sel_a;
    logic [SW-1:0]         w_sel_b;

    // Decode-side source qualifiers: x0 and unread fields never create hazards
    logic                  w_de_rs1_live;
    logic                  w_de_rs2_live;
    logic                  w_ex_rs1_live;
    logic                  w_ex_rs2_live;

    assign w_de_rs1_live = de_rs1_used && (de_rs1_addr != 5'd0);
    assign w_de_rs2_live = de_rs2_used && (de_rs2_addr != 5'd0);
    assign w_ex_rs1_live = r_ex_rs1_used && (r_ex_rs1 != 5'd0);
    assign w_ex_rs2_live = r_ex_rs2_used && (r_ex_rs2 != 5'd0);

    // ------------------------------------------------------------------
    // Producer detection for the EX sources in stages 2..NUM_STAGES
    // ------------------------------------------------------------------
    generate
        for (genvar k = 2; k <= NUM_STAGES; k++) begin : g_producer
            logic w_writes;
            assign w_writes    = r_valid[k] && r_reg_write[k] && (r_rd[k] != 5'd0);
            assign w_prod_a[k] = w_writes && (r_rd[k] == r_ex_rs1);
            assign w_prod_b[k] = w_writes && (r_rd[k] == r_ex_rs2);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load-use detection: decode sources against loads whose data does
    // not yet exist (stages 1..LOAD_LATENCY)
    // ------------------------------------------------------------------
    generate
        for (genvar k = 1; k <= LOAD_LATENCY; k++) begin : g_load_hit
            logic w_pending_load;
            assign w_pending_load = r_valid[k] && r_reg_write[k] && r_is_load[k]
                                    && (r_rd[k] != 5'd0);
            assign w_load_hit[k]  = w_pending_load
                                    && ((w_de_rs1_live && (r_rd[k] == de_rs1_addr))
                                     || (w_de_rs2_live && (r_rd[k] == de_rs2_addr)));
        end
    endgenerate

    assign w_load_hazard = |w_load_hit;

    // Redirect wins over stall: the decode instruction is discarded anyway
    assign w_stall  = de_valid && !ex_redirect && w_load_hazard;
    assign w_accept = de_valid && !w_stall && !ex_redirect;

    // Forwarding select per EX source; scan oldest to youngest so the youngest producer wins
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = NUM_STAGES; k >= 2; k--) begin
            if (w_ex_rs1_live && w_prod_a[k]) begin
                w_sel_a = SW'(k);
            end
            if (w_ex_rs2_live && w_prod_b[k]) begin
                w_sel_b = SW'(k);
            end
        end
    end

    assign stall     = w_stall;
    assign ex_bubble = w_stall || ex_redirect || !de_valid;
    assign flush     = ex_redirect;
    assign fwd_sel_a = w_sel_a;
    assign fwd_sel_b = w_sel_b;

    // Scoreboard shift: stage 1 takes decode or a bubble, older entries advance, WB retires
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_valid       <= '0;
            r_reg_write   <= '0;
            r_is_load     <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                r_rd[k] <= 5'd0;
            end
            r_ex_rs1      <= 5'd0;
            r_ex_rs2      <= 5'd0;
            r_ex_rs1_used <= 1'b0;
            r_ex_rs2_used <= 1'b0;
        end else begin
            // Stage 1: bubbles carry all-zero fields so stale data never matches
            r_valid[1]     <= w_accept;
            r_reg_write[1] <= w_accept && de_reg_write;
            r_is_load[1]   <= w_accept && de_is_load;
            r_rd[1]        <= w_accept ? de_rd_addr  : 5'd0;
            r_ex_rs1       <= w_accept ? de_rs1_addr : 5'd0;
            r_ex_rs2       <= w_accept ? de_rs2_addr : 5'd0;
            r_ex_rs1_used  <= w_accept && de_rs1_used;
            r_ex_rs2_used  <= w_accept && de_rs2_used;

            for (int k = 2; k <= NUM_STAGES; k++) begin
                r_valid[k]     <= r_valid[k-1];
                r_reg_write[k] <= r_reg_write[k-1];
                r_rd[k]        <= r_rd[k-1];
            end
            for (int k = 2; k <= LOAD_LATENCY; k++) begin
                r_is_load[k] <= r_is_load[k-1];
            end
        end
    end

    // Saturating event counters for stalls and flushes
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (ex_redirect && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_otter_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_hazard_unit
// Description : Directed self-checking bench for otter_hazard_unit. One
//               instance with the default pipeline shape, one with a deeper
//               pipeline and two-cycle load latency; both share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_hazard_unit;

    localparam int c_CNT_W = 10;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    logic       CLK;
    logic       RESET_N;
    logic       de_valid;
    logic [4:0] de_rs1_addr;
    logic [4:0] de_rs2_addr;
    logic       de_rs1_used;
    logic       de_rs2_used;
    logic [4:0] de_rd_addr;
    logic       de_reg_write;
    logic       de_is_load;
    logic       ex_redirect;

    logic               stall, ex_bubble, flush;
    logic [1:0]         fwd_sel_a, fwd_sel_b;
    logic [c_CNT_W-1:0] stall_count, flush_count;

    logic               d2_stall, d2_ex_bubble, d2_flush;
    logic [2:0]         d2_fwd_sel_a, d2_fwd_sel_b;
    logic [c_CNT_W-1:0] d2_stall_count, d2_flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    otter_hazard_unit #(
        .NUM_STAGES   (3),
        .LOAD_LATENCY (1),
        .CNT_W        (c_CNT_W)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .de_valid     (de_valid),
        .de_rs1_addr  (de_rs1_addr),
        .de_rs2_addr  (de_rs2_addr),
        .de_rs1_used  (de_rs1_used),
        .de_rs2_used  (de_rs2_used),
        .de_rd_addr   (de_rd_addr),
        .de_reg_write (de_reg_write),
        .de_is_load   (de_is_load),
        .ex_redirect  (ex_redirect),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    otter_hazard_unit #(
        .NUM_STAGES   (4),
        .LOAD_LATENCY (2),
        .CNT_W        (c_CNT_W)
    ) dut2 (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .de_valid     (de_valid),
        .de_rs1_addr  (de_rs1_addr),
        .de_rs2_addr  (de_rs2_addr),
        .de_rs1_used  (de_rs1_used),
        .de_rs2_used  (de_rs2_used),
        .de_rd_addr   (de_rd_addr),
        .de_reg_write (de_reg_write),
        .de_is_load   (de_is_load),
        .ex_redirect  (ex_redirect),
        .stall        (d2_stall),
        .ex_bubble    (d2_ex_bubble),
        .flush        (d2_flush),
        .fwd_sel_a    (d2_fwd_sel_a),
        .fwd_sel_b    (d2_fwd_sel_b),
        .stall_count  (d2_stall_count),
        .flush_count  (d2_flush_count)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Global time bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle inputs #1 later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic de_set(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ld);
        de_valid     = v;
        de_rs1_addr  = rs1;
        de_rs1_used  = u1;
        de_rs2_addr  = rs2;
        de_rs2_used  = u2;
        de_rd_addr   = rd;
        de_reg_write = rw;
        de_is_load   = ld;
    endtask

    task automatic op_idle();
        de_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic op_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        de_set(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic op_load(input logic [4:0] rd, input logic [4:0] rs1);
        de_set(1'b1, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
    endtask

    task automatic drain();
        op_idle();
        ex_redirect = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        op_idle();
        ex_redirect = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
        #1;
    endtask

    initial begin
        RESET_N     = 1'b0;
        ex_redirect = 1'b0;
        op_idle();
        do_reset();

        // Reset state with decode empty
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_fwd_a", 32'(fwd_sel_a), 0);
        check("rst_fwd_b", 32'(fwd_sel_b), 0);
        check("rst_bubble", 32'(ex_bubble), 1);
        check("rst_stall_cnt", 32'(stall_count), 0);
        check("rst_flush_cnt", 32'(flush_count), 0);

        // ALU chain: add x5 ; add x6,x5,x5
        op_alu(5'd5, 5'd1, 5'd2);
        #1;
        check("alu_prod_stall", 32'(stall), 0);
        check("alu_prod_bubble", 32'(ex_bubble), 0);
        tick();
        op_alu(5'd6, 5'd5, 5'd5);
        #1;
        check("alu_dep_stall", 32'(stall), 0);
        tick();
        op_alu(5'd13, 5'd6, 5'd5);
        #1;
        check("alu_fwd_a", 32'(fwd_sel_a), 2);
        check("alu_fwd_b", 32'(fwd_sel_b), 2);
        check("alu_fwd_stall", 32'(stall), 0);
        tick();
        // add x13,x6,x5: x6 one stage ahead, x5 two stages ahead
        op_idle();
        #1;
        check("split_fwd_a", 32'(fwd_sel_a), 2);
        check("split_fwd_b", 32'(fwd_sel_b), 3);
        drain();

        // Youngest producer wins: add x5 ; add x5 ; add x9,x5,x0
        op_alu(5'd5, 5'd1, 5'd2);
        tick();
        op_alu(5'd5, 5'd3, 5'd4);
        tick();
        op_alu(5'd9, 5'd5, 5'd0);
        tick();
        op_idle();
        #1;
        check("young_fwd_a", 32'(fwd_sel_a), 2);
        check("young_fwd_b_x0", 32'(fwd_sel_b), 0);
        drain();

        // Load-use: lw x7 ; add x8,x7,x1
        op_load(5'd7, 5'd1);
        #1;
        check("ld_stall_pre", 32'(stall), 0);
        tick();
        op_alu(5'd8, 5'd7, 5'd1);
        #1;
        check("ld_use_stall", 32'(stall), 1);
        check("ld_use_bubble", 32'(ex_bubble), 1);
        tick();
        #1;
        check("ld_use_release", 32'(stall), 0);
        check("ld_use_rel_bubble", 32'(ex_bubble), 0);
        check("ld_use_stall_cnt", 32'(stall_count), 1);
        tick();
        op_idle();
        #1;
        // One bubble separates them, so the load sits two stages ahead (WB)
        check("ld_use_fwd_a", 32'(fwd_sel_a), 3);
        check("ld_use_fwd_b", 32'(fwd_sel_b), 0);
        drain();

        // x0 destination load followed by reads of x0
        op_load(5'd0, 5'd1);
        tick();
        op_alu(5'd9, 5'd0, 5'd0);
        #1;
        check("x0_stall", 32'(stall), 0);
        tick();
        op_idle();
        #1;
        check("x0_fwd_a", 32'(fwd_sel_a), 0);
        check("x0_fwd_b", 32'(fwd_sel_b), 0);
        drain();

        // LUI whose rs1 field equals the load rd but is not read
        op_load(5'd7, 5'd1);
        tick();
        de_set(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd10, 1'b1, 1'b0);
        #1;
        check("lui_stall", 32'(stall), 0);
        tick();
        op_idle();
        #1;
        check("lui_fwd_a", 32'(fwd_sel_a), 0);
        drain();

        // Redirect coincident with a load-use hazard
        op_load(5'd7, 5'd1);
        tick();
        op_alu(5'd8, 5'd7, 5'd1);
        ex_redirect = 1'b1;
        #1;
        check("redir_flush", 32'(flush), 1);
        check("redir_stall", 32'(stall), 0);
        check("redir_bubble", 32'(ex_bubble), 1);
        tick();
        ex_redirect = 1'b0;
        op_alu(5'd11, 5'd8, 5'd8);
        #1;
        check("redir_flush_cnt", 32'(flush_count), 1);
        check("redir_stall_cnt", 32'(stall_count), 1);
        check("redir_flush_off", 32'(flush), 0);
        tick();
        op_idle();
        #1;
        // The discarded add x8 must not appear as a producer
        check("redir_no_fwd_a", 32'(fwd_sel_a), 0);
        check("redir_no_fwd_b", 32'(fwd_sel_b), 0);
        drain();

        // Reset mid-stall with three valid entries
        op_alu(5'd5, 5'd1, 5'd2);
        tick();
        op_alu(5'd6, 5'd1, 5'd2);
        tick();
        op_load(5'd7, 5'd1);
        tick();
        op_alu(5'd12, 5'd7, 5'd6);
        #1;
        check("mid_stall_pre", 32'(stall), 1);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_flush", 32'(flush), 0);
        check("mid_rst_bubble", 32'(ex_bubble), 0);
        check("mid_rst_stall_cnt", 32'(stall_count), 0);
        check("mid_rst_flush_cnt", 32'(flush_count), 0);
        tick();
        op_idle();
        #1;
        check("mid_rst_fwd_a", 32'(fwd_sel_a), 0);
        check("mid_rst_fwd_b", 32'(fwd_sel_b), 0);

        // Deeper pipeline with two-cycle load latency
        do_reset();
        op_load(5'd7, 5'd1);
        tick();
        op_alu(5'd8, 5'd7, 5'd1);
        #1;
        check("ll2_stall_1", 32'(d2_stall), 1);
        tick();
        #1;
        check("ll2_stall_2", 32'(d2_stall), 1);
        tick();
        #1;
        check("ll2_release", 32'(d2_stall), 0);
        tick();
        op_idle();
        #1;
        check("ll2_fwd_a", 32'(d2_fwd_sel_a), 4);
        check("ll2_fwd_b", 32'(d2_fwd_sel_b), 0);
        check("ll2_stall_cnt", 32'(d2_stall_count), 2);

        // Counter saturation: one stall every two cycles, past the top value
        do_reset();
        for (int i = 0; i < c_CNT_MAX + 6; i++) begin
            op_load(5'd7, 5'd1);
            tick();
            op_alu(5'd8, 5'd7, 5'd1);
            tick();
            if (i == c_CNT_MAX - 2) begin
                check("sat_stall_near", 32'(stall_count), 32'(c_CNT_MAX - 1));
            end
        end
        check("sat_stall_hold", 32'(stall_count), 32'(c_CNT_MAX));
        op_idle();
        ex_redirect = 1'b1;
        repeat (c_CNT_MAX + 6) tick();
        ex_redirect = 1'b0;
        #1;
        check("sat_flush_hold", 32'(flush_count), 32'(c_CNT_MAX));
        check("sat_stall_keep", 32'(stall_count), 32'(c_CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
